// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state encoding and the bitwise helper functions.
// Shared by the streaming engine and its round datapath.
package sha256_pkg;

    typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

    typedef struct packed {
        logic [31:0] a, b, c, d, e, f, g, h;
    } work_t;

    localparam logic [31:0] H_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd2) ^ rightrotate(x, 5'd13) ^ rightrotate(x, 5'd22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd6) ^ rightrotate(x, 5'd11) ^ rightrotate(x, 5'd25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd7) ^ rightrotate(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd17) ^ rightrotate(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational.
// Latency 0; no flow control, the caller registers the result.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       i_v,
    input  logic [31:0] i_w,
    input  logic [31:0] i_k,
    output work_t       o_v
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = i_v.h + Sigma1(i_v.e) + ch(i_v.e, i_v.f, i_v.g) + i_k + i_w;
    assign w_t2 = Sigma0(i_v.a) + maj(i_v.a, i_v.b, i_v.c);

    assign o_v = {w_t1 + w_t2, i_v.a, i_v.b, i_v.c, i_v.d + w_t1, i_v.e, i_v.f, i_v.g};

endmodule

// File: rtl/sha256_stream.sv
// Streams a NUM_OF_WORDS-word message from memory through SHA-256 and writes the 8-word digest back.
// Latency 82*NUM_BLOCKS+8 cycles start-to-done; no backpressure, memory assumed to return data one cycle after the address.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam logic [15:0] LAST_BLK   = 16'(NUM_BLOCKS - 1);
    localparam logic [15:0] MSG_WORDS  = 16'(NUM_OF_WORDS);
    localparam logic [31:0] MSG_BITS   = 32'(NUM_OF_WORDS * 32);

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_blk;
    logic [15:0] r_msg_addr;
    logic [15:0] r_out_addr;
    logic [15:0] r_addr_hold;
    logic [31:0] r_h [0:7];
    logic [31:0] r_win [0:15];
    work_t       r_v, w_v_nxt;

    logic        w_last_blk;
    logic [3:0]  w_k;
    logic [15:0] w_g;
    logic [31:0] w_word;
    logic [31:0] w_sched;
    logic [31:0] w_h_new [0:7];

    assign w_last_blk = (r_blk == LAST_BLK);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 7'd1;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (start) w_state_nxt = READ;
            end
            READ: begin
                if (r_cnt == 7'd16) begin
                    w_state_nxt = COMPUTE;
                    w_cnt_nxt   = '0;
                end
            end
            COMPUTE: begin
                if (r_cnt == 7'd63) begin
                    w_state_nxt = UPDATE;
                    w_cnt_nxt   = '0;
                end
            end
            UPDATE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = w_last_blk ? WRITE : READ;
            end
            WRITE: begin
                if (r_cnt == 7'd7) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign done    = (r_state == IDLE);
    assign mem_clk = clk;
    assign mem_we  = (r_state == WRITE);

    always_comb begin
        mem_addr       = r_addr_hold;
        mem_write_data = '0;
        if (r_state == READ && r_cnt < 7'd16) begin
            mem_addr = r_msg_addr + {r_blk[11:0], 4'b0000} + {12'b0, r_cnt[3:0]};
        end else if (r_state == WRITE) begin
            mem_addr       = r_out_addr + {13'b0, r_cnt[2:0]};
            mem_write_data = r_h[r_cnt[2:0]];
        end
    end

    // Word k of the block arrives one cycle after its address, so it is captured at r_cnt = k+1.
    assign w_k = 4'(r_cnt - 7'd1);
    assign w_g = {r_blk[11:0], 4'b0000} + {12'b0, w_k};

    always_comb begin
        w_word = '0;
        if (w_g < MSG_WORDS) begin
            w_word = mem_read_data;
        end else if (w_g == MSG_WORDS) begin
            w_word = 32'h8000_0000;
        end else if (w_last_blk && w_k == 4'd15) begin
            w_word = MSG_BITS;
        end
    end

    // Window holds W[t..t+15]; this yields W[t+16] for the entry shifted in.
    assign w_sched = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_h_new[i] = r_h[i] + r_v[255 - 32*i -: 32];
        end
    end

    sha256_round u_round (
        .i_v (r_v),
        .i_w (r_win[0]),
        .i_k (K[r_cnt[5:0]]),
        .o_v (w_v_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_msg_addr  <= '0;
            r_out_addr  <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr_hold <= mem_addr;
            if (r_state == IDLE && start) begin
                r_msg_addr <= message_addr;
                r_out_addr <= output_addr;
                r_blk      <= '0;
            end else if (r_state == UPDATE && !w_last_blk) begin
                r_blk <= r_blk + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 8; i++) r_h[i] <= H_IV[i];
                    r_v <= {H_IV[0], H_IV[1], H_IV[2], H_IV[3], H_IV[4], H_IV[5], H_IV[6], H_IV[7]};
                end
            end
            READ: begin
                if (r_cnt != 7'd0) begin
                    for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                    r_win[15] <= w_word;
                end
            end
            COMPUTE: begin
                r_v <= w_v_nxt;
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                r_win[15] <= w_sched;
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) r_h[i] <= w_h_new[i];
                r_v <= {w_h_new[0], w_h_new[1], w_h_new[2], w_h_new[3],
                        w_h_new[4], w_h_new[5], w_h_new[6], w_h_new[7]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: four instances (20, 13, 14, 16 words) run random messages
// against a plain software SHA-256; a per-instance monitor checks every memory write.
module tb_sha256_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-message reference: pad into a flat word queue, then a full 64-entry schedule per block.
    function automatic logic [255:0] ref_sha(input logic [31:0] msg [$]);
        logic [31:0] p [$];
        logic [31:0] w [64];
        logic [31:0] h [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] d;
        p = msg;
        p.push_back(32'h8000_0000);
        while (p.size() % 16 != 14) p.push_back(32'h0);
        p.push_back(32'h0);
        p.push_back(32'(msg.size() * 32));
        for (int i = 0; i < 8; i++) h[i] = IV[i];
        for (int b = 0; b < p.size() / 16; b++) begin
            for (int t = 0; t < 64; t++) begin
                if (t < 16) begin
                    w[t] = p[16*b + t];
                end else begin
                    s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                    s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                    w[t] = s1 + w[t-7] + s0 + w[t-16];
                end
            end
            for (int i = 0; i < 8; i++) v[i] = h[i];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
                t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
                v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        for (int i = 0; i < 8; i++) d[255 - 32*i -: 32] = h[i];
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [3:0] all_fin;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int N   = (gi == 0) ? 20 : (gi == 1) ? 13 : (gi == 2) ? 14 : 16;
        localparam int NB  = (N + 18) / 16;
        localparam int LAT = 82 * NB + 8;

        logic        reset_n;
        logic        start;
        logic [15:0] message_addr;
        logic [15:0] output_addr;
        logic        done;
        logic        mem_clk;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [31:0] mem_write_data;
        logic [31:0] mem_read_data;

        logic [31:0] mem [0:65535];
        logic [31:0] msg [$];
        logic [15:0] exp_addr [$];
        logic [31:0] exp_data [$];
        bit          fin = 1'b0;

        assign all_fin[gi] = fin;

        sha256_stream #(.NUM_OF_WORDS(N)) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start),
            .message_addr   (message_addr),
            .output_addr    (output_addr),
            .done           (done),
            .mem_clk        (mem_clk),
            .mem_we         (mem_we),
            .mem_addr       (mem_addr),
            .mem_write_data (mem_write_data),
            .mem_read_data  (mem_read_data)
        );

        always @(posedge clk) mem_read_data <= mem[mem_addr];

        initial forever begin
            @(negedge clk);
            if (mem_we) begin
                if (exp_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL N%0d unexpected write: addr %h data %h, none expected", N, mem_addr, mem_write_data);
                end else begin
                    check($sformatf("N%0d write addr", N), {16'h0, mem_addr}, {16'h0, exp_addr.pop_front()});
                    check($sformatf("N%0d write data", N), mem_write_data, exp_data.pop_front());
                end
            end
        end

        task automatic gen_msg();
            msg = {};
            for (int i = 0; i < N; i++) msg.push_back($urandom);
        endtask

        // Words after the message are random so any read past the end corrupts the digest.
        task automatic place(input logic [15:0] ma);
            for (int i = 0; i < N; i++) mem[ma + 16'(i)] = msg[i];
            for (int i = N; i < N + 16; i++) mem[ma + 16'(i)] = $urandom;
        endtask

        task automatic expect_digest(input logic [15:0] oa);
            logic [255:0] d = ref_sha(msg);
            for (int i = 0; i < 8; i++) begin
                exp_addr.push_back(oa + 16'(i));
                exp_data.push_back(d[255 - 32*i -: 32]);
            end
        endtask

        task automatic pulse_start(input logic [15:0] ma, input logic [15:0] oa);
            message_addr = ma;
            output_addr  = oa;
            start        = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check($sformatf("N%0d done falls", N), 32'(done), 32'd0);
        endtask

        // Entered 1 time unit after the edge that sampled start.
        task automatic wait_done(input string name);
            int c = 0;
            while (!done && c < LAT + 40) begin
                @(posedge clk); #1;
                c++;
            end
            check($sformatf("N%0d %s latency", N, name), 32'(c), 32'(LAT));
        endtask

        initial begin
            reset_n      = 1'b0;
            start        = 1'b0;
            message_addr = '0;
            output_addr  = '0;
            #2;
            check($sformatf("N%0d reset done", N), 32'(done), 32'd1);
            check($sformatf("N%0d reset we", N), 32'(mem_we), 32'd0);
            check($sformatf("N%0d reset addr", N), {16'h0, mem_addr}, 32'd0);
            check($sformatf("N%0d reset wdata", N), mem_write_data, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("N%0d mem_clk", N), 32'(mem_clk), 32'(clk));
            reset_n = 1'b1;
            @(posedge clk); #1;
            check($sformatf("N%0d idle done", N), 32'(done), 32'd1);

            gen_msg();
            place(16'h0000);
            expect_digest(16'h0080);
            pulse_start(16'h0000, 16'h0080);
            wait_done("run1");

            gen_msg();
            place(16'h0100);
            pulse_start(16'h0100, 16'h0180);
            repeat (57) @(posedge clk);
            #1;
            check($sformatf("N%0d busy before abort", N), 32'(done), 32'd0);
            reset_n = 1'b0;
            #1;
            check($sformatf("N%0d abort done", N), 32'(done), 32'd1);
            check($sformatf("N%0d abort we", N), 32'(mem_we), 32'd0);
            check($sformatf("N%0d abort addr", N), {16'h0, mem_addr}, 32'd0);
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(posedge clk); #1;

            gen_msg();
            place(16'h0100);
            expect_digest(16'h0180);
            pulse_start(16'h0100, 16'h0180);
            wait_done("after abort");

            gen_msg();
            place(16'h0200);
            place(16'h0300);
            expect_digest(16'h0280);
            expect_digest(16'h0380);
            message_addr = 16'h0200;
            output_addr  = 16'h0280;
            start        = 1'b1;
            @(posedge clk); #1;
            check($sformatf("N%0d held done falls", N), 32'(done), 32'd0);
            message_addr = 16'h0300;
            output_addr  = 16'h0380;
            wait_done("held run1");
            @(posedge clk); #1;
            check($sformatf("N%0d done one cycle", N), 32'(done), 32'd0);
            start = 1'b0;
            wait_done("held run2");

            gen_msg();
            place(16'hFFF8);
            expect_digest(16'hFFFC);
            pulse_start(16'hFFF8, 16'hFFFC);
            wait_done("wrap");

            repeat (5) @(posedge clk);
            #1;
            check($sformatf("N%0d writes outstanding", N), 32'(exp_addr.size()), 32'd0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && all_fin != 4'hF; c++) @(posedge clk);
        if (all_fin != 4'hF) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: finished mask %b, expected 1111", all_fin);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_stream.md
Name: sha256_stream

Overview:
- Parametrised SHA-256 engine for the memory-mapped hash path.
- Hashes a word-aligned message of NUM_OF_WORDS 32-bit words starting at message_addr, and writes the 8-word digest to output_addr.
- Any message length is supported: padding and the 64-bit length field are generated on the fly.
- Message is streamed one 512-bit block at a time; only a 16-word schedule window is held, never the whole message.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4095.
- NUM_BLOCKS (localparam), (NUM_OF_WORDS+3+15)/16 using integer division, number of padded 512-bit blocks.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- message_addr  in  16  word address of message word 0; latched when start is accepted.
- output_addr  in  16  word address of digest word H0; latched when start is accepted.
- done  out  1  high while in IDLE.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory word address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  synchronous read data: valid the cycle after its address is presented.

Behaviour:
- Reset: state IDLE; done=1, mem_we=0, mem_addr=0, mem_write_data=0. Reset is asynchronous and aborts any operation in progress. No further writes occur after reset asserts; partial digest words already written are left in memory.
- IDLE:
  - When start=1, latch both addresses and load H0..H7 and a..h with the standard IVs. Set blk=0. Go to READ.
  - done falls the cycle after start is sampled.
- READ, 17 cycles per block:
  - Cycles k=0..15 present mem_addr = message_addr + 16*blk + k. The data returned for word k is captured at cycle k+1 into W[k].
  - Word content uses global index g = 16*blk + k:
    - g < NUM_OF_WORDS: memory data.
    - g == NUM_OF_WORDS: 32'h80000000.
    - Last block, k=14: 32'h0 (high half of the length).
    - Last block, k=15: 32*NUM_OF_WORDS (low half of the length).
    - Otherwise: 0.
  - For padding words mem_addr is don't-care and no data is used.
- COMPUTE, 64 cycles, one round per cycle, t=0..63:
  - Rounds t<16 use W[t].
  - Rounds t>=16 use W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], computed from the 16-entry shift window. The window shifts once per round.
  - All additions are modulo 2^32.
- UPDATE, 1 cycle:
  - Hi <= Hi + reg_i for all i, and a..h <= new Hi.
  - If blk < NUM_BLOCKS-1: blk++ and go to READ. Otherwise go to WRITE.
- WRITE, 8 cycles, i=0..7: mem_we=1, mem_addr = output_addr + i, mem_write_data = Hi. Then go to IDLE with mem_we=0.
- Latency: done re-asserts exactly 82*NUM_BLOCKS + 8 cycles after the edge that samples start.
- start is ignored outside IDLE. If start is still high when IDLE is re-entered, a new hash begins on the next edge, so done is high for exactly 1 cycle.
- Address arithmetic wraps modulo 2^16.
- Outside READ and WRITE, mem_we=0 and mem_addr holds its last value.

Decomposition:
- sha256_pkg holds:
  - the K[0:63] table and the H IV constants;
  - the state enum {IDLE, READ, COMPUTE, UPDATE, WRITE};
  - the functions rightrotate, Sigma0/1, sigma0/1, ch, maj.
- One combinational sub-module, sha256_round:
  - inputs: a..h, W, K;
  - outputs: next a..h.
- Padding and word selection, the schedule window and the FSM stay in sha256_stream.

Test Plan:
- NUM_OF_WORDS=20, random message at 0x0000, output 0x0080 -> digest matches software golden model; done rises 172 cycles after start; exactly 8 write cycles at 0x0080..0x0087.
- NUM_OF_WORDS=13 (single-block boundary) -> W[13]=80000000, W[14]=0, W[15]=0x1A0; 1 block; latency 90; digest matches golden.
- NUM_OF_WORDS=14 -> 2 blocks; block0 W[14]=80000000, W[15]=0; block1 W[14]=0, W[15]=0x1C0; digest matches golden; no memory reads beyond message_addr+13 are used.
- NUM_OF_WORDS=16 -> block1 W[0]=80000000; block1 W[15]=0x200; digest matches golden.
- reset_n pulsed low at cycle 40 of COMPUTE -> mem_we=0 and done=1 in the same cycle; a fresh start then yields the correct digest.
- start held high across two runs -> done high for 1 cycle between runs; both digests identical; addresses re-latched per run.
